// File: rtl/disp_demux.sv
// Receive side of the multiplexed 7-segment bus: rebuilds the four
// digit registers from the time-multiplexed an/sseg lines.
module disp_demux #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int MATCH_COUNT    = 2,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] an,
  input  logic [7:0] sseg,
  output logic [7:0] dig_0,
  output logic [7:0] dig_1,
  output logic [7:0] dig_2,
  output logic [7:0] dig_3,
  output logic [3:0] valid,
  output logic [3:0] update,
  output logic       an_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int MW = $clog2(MATCH_COUNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_MAX   = MW'(MATCH_COUNT);
  localparam logic [TW-1:0] TO_MAX      = TW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [3:0]    an_q;
  logic [7:0]    sseg_q;
  logic          ill_q;
  logic [1:0]    state, state_nxt;
  logic [3:0]    pat, pat_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          go;

  logic [7:0]    dig_r  [4];
  logic [7:0]    cand   [4];
  logic [MW-1:0] mc     [4];
  logic [MW-1:0] mc_nxt [4];
  logic [TW-1:0] to_cnt [4];
  logic [3:0]    samp;
  logic [3:0]    commit;

  logic [3:0] an_lo;
  logic       is_blank;
  logic       is_legal;
  logic       is_ill;
  logic       held;

  assign an_lo    = ~an_q;
  assign is_blank = (an_q == 4'hF);
  assign is_legal = (an_lo != 4'h0) && ((an_lo & (an_lo - 4'd1)) == 4'h0);
  assign is_ill   = !is_blank && !is_legal;
  assign held     = (an_q == pat);

  // sseg_q only belongs to the latched digit while the pattern still holds
  assign samp = (state == S_SAMPLE && held) ? ~pat : 4'h0;

  assign dig_0 = dig_r[0];
  assign dig_1 = dig_r[1];
  assign dig_2 = dig_r[2];
  assign dig_3 = dig_r[3];

  always_comb begin
    state_nxt = state;
    pat_nxt   = pat;
    cnt_nxt   = cnt;
    go        = 1'b0;
    unique case (state)
      S_IDLE:   go = 1'b1;
      S_SETTLE: begin
        if (!held)
          go = 1'b1;
        else if (cnt == SETTLE_LAST)
          state_nxt = S_SAMPLE;
        else
          cnt_nxt = cnt + CW'(1);
      end
      S_SAMPLE: begin
        if (held) state_nxt = S_DONE;
        else      go = 1'b1;
      end
      S_DONE:   go = !held;
      default:  go = 1'b1;
    endcase
    if (go) begin
      if (is_legal) begin
        state_nxt = S_SETTLE;
        pat_nxt   = an_q;
        cnt_nxt   = '0;
      end else begin
        state_nxt = S_IDLE;
      end
    end
  end

  always_comb begin
    commit = '0;
    for (int n = 0; n < 4; n++) begin
      mc_nxt[n] = MW'(1);
      if (sseg_q == cand[n])
        mc_nxt[n] = (mc[n] == MATCH_MAX) ? MATCH_MAX : mc[n] + MW'(1);
      commit[n] = samp[n] && (mc_nxt[n] == MATCH_MAX);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q   <= 4'hF;
      sseg_q <= '0;
      ill_q  <= 1'b0;
      an_err <= 1'b0;
      state  <= S_IDLE;
      pat    <= 4'hF;
      cnt    <= '0;
      valid  <= '0;
      update <= '0;
      for (int n = 0; n < 4; n++) begin
        dig_r[n]  <= '0;
        cand[n]   <= '0;
        mc[n]     <= '0;
        to_cnt[n] <= '0;
      end
    end else begin
      an_q   <= an;
      sseg_q <= sseg;
      ill_q  <= is_ill;
      an_err <= is_ill && !ill_q;
      state  <= state_nxt;
      pat    <= pat_nxt;
      cnt    <= cnt_nxt;
      update <= '0;
      for (int n = 0; n < 4; n++) begin
        if (samp[n]) begin
          cand[n]   <= sseg_q;
          mc[n]     <= mc_nxt[n];
          to_cnt[n] <= '0;
        end else if (to_cnt[n] != TO_MAX) begin
          to_cnt[n] <= to_cnt[n] + TW'(1);
        end
        if (commit[n]) begin
          dig_r[n]  <= sseg_q;
          valid[n]  <= 1'b1;
          update[n] <= !valid[n] || (dig_r[n] != sseg_q);
        end else if (!samp[n] && to_cnt[n] == TO_MAX) begin
          valid[n] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_demux.sv
// Directed bench for disp_demux: update pulses are matched against a
// scoreboard filled by a small behavioural model as dwells are driven.
module tb_disp_demux;

  localparam int SC = 4;
  localparam int MC = 2;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] sseg;
  logic [7:0] dig_0, dig_1, dig_2, dig_3;
  logic [3:0] valid;
  logic [3:0] update;
  logic       an_err;

  disp_demux #(
    .SETTLE_CYCLES (SC),
    .MATCH_COUNT   (MC),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .an     (an),
    .sseg   (sseg),
    .dig_0  (dig_0),
    .dig_1  (dig_1),
    .dig_2  (dig_2),
    .dig_3  (dig_3),
    .valid  (valid),
    .update (update),
    .an_err (an_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_err = 0;
  int cyc = 0;

  logic [11:0] sb [$];
  logic [7:0]  digs [4];
  logic [7:0]  vals [4];
  logic [7:0]  cand_m [4];
  logic [7:0]  dig_m [4];
  int          mc_m [4];
  int          last_s [4];
  logic [3:0]  val_m;

  assign digs[0] = dig_0;
  assign digs[1] = dig_1;
  assign digs[2] = dig_2;
  assign digs[3] = dig_3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (an_err === 1'b1) n_err++;
    for (int n = 0; n < 4; n++) begin
      if (update[n] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("update_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("update_value", {20'd0, 4'(n), digs[n]}, {20'd0, e});
        end
      end
    end
  end

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      cand_m[n] = 8'h00;
      dig_m[n]  = 8'h00;
      mc_m[n]   = 0;
      last_s[n] = 0;
    end
    val_m = 4'h0;
  endtask

  task automatic model_sample(input int n, input logic [7:0] v);
    if (cyc - last_s[n] >= TO + 2) val_m[n] = 1'b0;
    last_s[n] = cyc;
    if (v == cand_m[n]) begin
      if (mc_m[n] < MC) mc_m[n]++;
    end else begin
      cand_m[n] = v;
      mc_m[n]   = 1;
    end
    if (mc_m[n] == MC) begin
      if (!val_m[n] || dig_m[n] != v) sb.push_back({4'(n), v});
      dig_m[n]  = v;
      val_m[n]  = 1'b1;
    end
  endtask

  task automatic dwell(input int n, input logic [7:0] v,
                       input int len, input int gap);
    an   = ~(4'b0001 << n);
    sseg = v;
    if (len >= SC + 2) model_sample(n, v);
    repeat (len) @(negedge clk);
    if (gap > 0) begin
      an   = 4'hF;
      sseg = 8'h00;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dig"}, {dig_3, dig_2, dig_1, dig_0}, 32'h0);
    chk({tag, "_valid"}, {28'd0, valid}, 32'h0);
    chk({tag, "_update"}, {28'd0, update}, 32'h0);
    chk({tag, "_an_err"}, {31'd0, an_err}, 32'h0);
  endtask

  task automatic two_rounds();
    for (int r = 0; r < 2; r++)
      for (int n = 0; n < 4; n++) dwell(n, vals[n], 8, 0);
    an   = 4'hF;
    sseg = 8'h00;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_digs"}, {dig_3, dig_2, dig_1, dig_0},
        {vals[3], vals[2], vals[1], vals[0]});
    chk({tag, "_valid"}, {28'd0, valid}, 32'hF);
    chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int e0;
    vals[0] = 8'hC0;
    vals[1] = 8'hF9;
    vals[2] = 8'hA4;
    vals[3] = 8'hB0;
    reset = 1'b1;
    an    = 4'hF;
    sseg  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: two rotations commit all four digits
    two_rounds();
    chk_all("rot");

    // 2: short dwell never samples
    dwell(0, 8'h80, 3, 6);
    chk("short_dig0", {24'd0, dig_0}, 32'hC0);
    chk("short_sb", 32'(sb.size()), 32'd0);

    // 3: candidate needs two matching samples
    dwell(1, 8'h99, 8, 4);
    chk("m99_dig1", {24'd0, dig_1}, 32'hF9);
    dwell(1, 8'h92, 8, 4);
    chk("m92a_dig1", {24'd0, dig_1}, 32'hF9);
    dwell(1, 8'h92, 8, 4);
    chk("m92b_dig1", {24'd0, dig_1}, 32'h92);
    dwell(1, 8'h92, 8, 4);
    chk("m92c_dig1", {24'd0, dig_1}, 32'h92);
    chk("match_sb", 32'(sb.size()), 32'd0);
    vals[1] = 8'h92;

    // 4: refresh, then an illegal anode episode
    for (int n = 0; n < 4; n++) dwell(n, vals[n], 8, 0);
    an = 4'hF;
    repeat (4) @(negedge clk);
    e0   = n_err;
    an   = 4'b1100;
    sseg = 8'hFF;
    repeat (5) @(negedge clk);
    an   = 4'hF;
    sseg = 8'h00;
    repeat (6) @(negedge clk);
    chk("ill_err_pulses", 32'(n_err - e0), 32'd1);
    chk_all("ill");

    // 5: digit 2 starved past the timeout
    for (int r = 0; r < 4; r++) begin
      dwell(0, vals[0], 8, 0);
      dwell(1, vals[1], 8, 0);
      dwell(3, vals[3], 8, 0);
    end
    an = 4'hF;
    repeat (2) @(negedge clk);
    chk("to_valid", {28'd0, valid}, 32'hB);
    chk("to_dig2", {24'd0, dig_2}, 32'hA4);
    chk("to_sb", 32'(sb.size()), 32'd0);

    // 6a: reset while settling
    an   = 4'b1110;
    sseg = 8'hC0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_zero("rst_settle");
    model_reset();
    an   = 4'hF;
    sseg = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    two_rounds();
    chk_all("rec1");

    // 6b: reset late in a committed dwell
    an   = 4'b1110;
    sseg = 8'hC0;
    model_sample(0, 8'hC0);
    repeat (7) @(negedge clk);
    chk("dwell_dig0", {24'd0, dig_0}, 32'hC0);
    #2 reset = 1'b1;
    #1 chk_zero("rst_dwell");
    model_reset();
    an   = 4'hF;
    sseg = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    two_rounds();
    chk_all("rec2");

    chk("final_sb", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
